// File: rtl/bus_rr_xfer.sv
// Round-robin arbitrated transfer of M sources to M addressed destination registers over one shared registered bus.
// Optional BUS_LOCK_EN adds a per-source lock input that lets the granted source hold the bus for a burst.
module bus_rr_xfer #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef BUS_LOCK_EN
    input  logic [M-1:0]     lock,
`endif
    input  logic [M-1:0]     req,
    input  logic [M*N-1:0]   data_in,
    input  logic [M*$clog2(M)-1:0] dest,
    output logic [M-1:0]     grant,
    output logic [N-1:0]     bus,
    output logic             bus_valid,
    output logic [M*N-1:0]   data_out,
    output logic [M-1:0]     out_valid
);

    localparam int unsigned DW = $clog2(M);

    logic [DW-1:0]   ptr;
    logic [DW-1:0]   dest_q;

    logic            win_found_c;
    logic [DW-1:0]   win_idx_c;
    logic [DW-1:0]   ptr_nxt_c;
    logic [M-1:0]    grant_nxt_c;
    logic [N-1:0]    bus_nxt_c;
    logic [DW-1:0]   dest_nxt_c;
    logic [M-1:0]    wr_mask_c;
    int unsigned     dist_c;
    int unsigned     best_dist_c;
`ifdef BUS_LOCK_EN
    logic            lock_hit_c;
`endif

    // Winner is the requester closest to the pointer going upward with wrap.
    always_comb begin
        win_found_c = |req;
        win_idx_c   = '0;
        best_dist_c = M;
        dist_c      = 0;
        for (int unsigned j = 0; j < M; j++) begin
            dist_c = (j + M - 32'(ptr)) % M;
            if (req[j] && (dist_c < best_dist_c)) begin
                best_dist_c = dist_c;
                win_idx_c   = DW'(j);
            end
        end
        ptr_nxt_c = DW'((32'(win_idx_c) + 1) % M);
`ifdef BUS_LOCK_EN
        // A locked, still-requesting grant holder wins again and freezes the pointer.
        lock_hit_c = 1'b0;
        for (int unsigned j = 0; j < M; j++) begin
            if (grant[j] && lock[j] && req[j]) begin
                lock_hit_c = 1'b1;
                win_idx_c  = DW'(j);
            end
        end
        if (lock_hit_c) begin
            ptr_nxt_c = ptr;
        end
`endif
    end

    // Steer the winner's payload and destination index; build the one-hot grant.
    always_comb begin
        grant_nxt_c = '0;
        bus_nxt_c   = '0;
        dest_nxt_c  = '0;
        for (int unsigned j = 0; j < M; j++) begin
            if (DW'(j) == win_idx_c) begin
                grant_nxt_c[j] = win_found_c;
                bus_nxt_c      = data_in[j*N +: N];
                dest_nxt_c     = dest[j*DW +: DW];
            end
        end
    end

    // Out-of-range destination indices match no bit, so nothing is written.
    always_comb begin
        wr_mask_c = '0;
        for (int unsigned j = 0; j < M; j++) begin
            wr_mask_c[j] = bus_valid && (dest_q == DW'(j));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            dest_q    <= '0;
            grant     <= '0;
            bus       <= '0;
            bus_valid <= 1'b0;
        end else if (win_found_c) begin
            ptr       <= ptr_nxt_c;
            dest_q    <= dest_nxt_c;
            grant     <= grant_nxt_c;
            bus       <= bus_nxt_c;
            bus_valid <= 1'b1;
        end else begin
            grant     <= '0;
            bus_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            out_valid <= '0;
        end else begin
            out_valid <= wr_mask_c;
            for (int unsigned j = 0; j < M; j++) begin
                if (wr_mask_c[j]) begin
                    data_out[j*N +: N] <= bus;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_rr_xfer.sv
// Directed bench for bus_rr_xfer (N=8, M=4): vector table plus reset and burst-lock sequences.
module tb_bus_rr_xfer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [7:0]  dest;
    logic [3:0]  grant;
    logic [7:0]  bus;
    logic        bus_valid;
    logic [31:0] data_out;
    logic [3:0]  out_valid;
`ifdef BUS_LOCK_EN
    logic [3:0]  lock;
`endif

    int checks = 0;
    int errors = 0;

    bus_rr_xfer #(.N(8), .M(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef BUS_LOCK_EN
        .lock      (lock),
`endif
        .req       (req),
        .data_in   (data_in),
        .dest      (dest),
        .grant     (grant),
        .bus       (bus),
        .bus_valid (bus_valid),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] din;
        logic [7:0]  dst;
        logic [3:0]  g;
        logic [7:0]  b;
        logic        bv;
        logic [3:0]  ov;
        logic [31:0] dout;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Applied after reset release with pointer 0; each entry is one clock edge.
        vecs[0]  = '{4'hF, 32'h13121110, 8'h00, 4'h1, 8'h10, 1'b1, 4'h0, 32'h00000000};
        vecs[1]  = '{4'hF, 32'h13121110, 8'h00, 4'h2, 8'h11, 1'b1, 4'h1, 32'h00000010};
        vecs[2]  = '{4'hF, 32'h13121110, 8'h00, 4'h4, 8'h12, 1'b1, 4'h1, 32'h00000011};
        vecs[3]  = '{4'hF, 32'h13121110, 8'h00, 4'h8, 8'h13, 1'b1, 4'h1, 32'h00000012};
        vecs[4]  = '{4'hF, 32'h13121110, 8'h00, 4'h1, 8'h10, 1'b1, 4'h1, 32'h00000013};
        vecs[5]  = '{4'h0, 32'h13121110, 8'h00, 4'h0, 8'h10, 1'b0, 4'h1, 32'h00000010};
        vecs[6]  = '{4'h0, 32'h13121110, 8'h00, 4'h0, 8'h10, 1'b0, 4'h0, 32'h00000010};
        vecs[7]  = '{4'h4, 32'h00A20000, 8'h10, 4'h4, 8'hA2, 1'b1, 4'h0, 32'h00000010};
        vecs[8]  = '{4'h0, 32'h00A20000, 8'h10, 4'h0, 8'hA2, 1'b0, 4'h2, 32'h0000A210};
        vecs[9]  = '{4'h8, 32'h33000030, 8'h83, 4'h8, 8'h33, 1'b1, 4'h0, 32'h0000A210};
        vecs[10] = '{4'h9, 32'h33000030, 8'h83, 4'h1, 8'h30, 1'b1, 4'h4, 32'h0033A210};
        vecs[11] = '{4'h0, 32'h33000030, 8'h83, 4'h0, 8'h30, 1'b0, 4'h8, 32'h3033A210};
        vecs[12] = '{4'h2, 32'h00005400, 8'h00, 4'h2, 8'h54, 1'b1, 4'h0, 32'h3033A210};
        vecs[13] = '{4'h0, 32'h00005400, 8'h00, 4'h0, 8'h54, 1'b0, 4'h1, 32'h3033A254};
        vecs[14] = '{4'h0, 32'h00005400, 8'h00, 4'h0, 8'h54, 1'b0, 4'h0, 32'h3033A254};
        vecs[15] = '{4'hC, 32'h73620000, 8'h50, 4'h4, 8'h62, 1'b1, 4'h0, 32'h3033A254};
        vecs[16] = '{4'hC, 32'h73620000, 8'h50, 4'h8, 8'h73, 1'b1, 4'h2, 32'h30336254};
        vecs[17] = '{4'h0, 32'h73620000, 8'h50, 4'h0, 8'h73, 1'b0, 4'h2, 32'h30337354};
        vecs[18] = '{4'h0, 32'h73620000, 8'h50, 4'h0, 8'h73, 1'b0, 4'h0, 32'h30337354};

        rst_n   = 1'b0;
        req     = 4'hF;
        data_in = 32'h13121110;
        dest    = 8'h00;
`ifdef BUS_LOCK_EN
        lock    = 4'h0;
`endif

        // Requests held during reset must produce nothing.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("rst_grant", 32'(grant), 32'h0);
            chk("rst_bus", 32'(bus), 32'h0);
            chk("rst_out_valid", 32'(out_valid), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            req     = vecs[i].req;
            data_in = vecs[i].din;
            dest    = vecs[i].dst;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].g));
            chk($sformatf("v%0d_bus", i), 32'(bus), 32'(vecs[i].b));
            chk($sformatf("v%0d_bus_valid", i), 32'(bus_valid), 32'(vecs[i].bv));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("v%0d_data_out", i), data_out, vecs[i].dout);
            @(negedge clk);
        end

        // Reset in the middle of a beat drops it.
        req     = 4'h1;
        data_in = 32'h000000EE;
        dest    = 8'h02;
        @(posedge clk);
        #1;
        chk("mid_grant", 32'(grant), 32'h1);
        chk("mid_bus", 32'(bus), 32'hEE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_bus", 32'(bus), 32'h0);
        chk("mid_rst_bus_valid", 32'(bus_valid), 32'h0);
        chk("mid_rst_data_out", data_out, 32'h0);
        @(negedge clk);
        req   = 4'h0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("drop_out_valid", 32'(out_valid), 32'h0);
        chk("drop_data_out", data_out, 32'h0);
        chk("drop_bus_valid", 32'(bus_valid), 32'h0);
        @(negedge clk);

`ifdef BUS_LOCK_EN
        // Move the pointer to 1, then source 1 bursts three locked beats while source 0 waits.
        req     = 4'h1;
        data_in = 32'h00008300;
        dest    = 8'h00;
        @(posedge clk);
        #1;
        chk("lk_pre_grant", 32'(grant), 32'h1);
        @(negedge clk);
        req  = 4'h3;
        lock = 4'h2;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lk_beat%0d_grant", b), 32'(grant), 32'h2);
            chk($sformatf("lk_beat%0d_bus", b), 32'(bus), 32'h83);
            @(negedge clk);
            if (b == 2) lock = 4'h0;
        end
        @(posedge clk);
        #1;
        chk("lk_release_grant", 32'(grant), 32'h1);
        @(negedge clk);
        req = 4'h0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
